exec_stage_mc: RTL and testbench

Parameterised execute stage for the pipelined ARM core. It owns the D/E and E/M pipeline registers, the forwarding muxes, the ALU, the NZCV flag register and ARM condition evaluation. It adds an optional iterative shift-add multiplier that holds the stage busy for a fixed number of cycles. It sits between decode and the memory stage, under control of the hazard unit.

---
 rtl/exec_stage_mc.sv | 278 +++++++++++++++++++++++++++
 tb/tb_exec_stage_mc.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_stage_mc.sv
// Execute stage: D/E and E/M registers, forwarding, ALU, NZCV flags, ARM condition check.
// Define EXEC_MUL_EN to build in the iterative shift-add multiplier (busyE held for WIDTH+1 cycles).
module exec_stage_mc #(
    parameter int WIDTH = 32,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stallE,
    input  logic             flushE,
    input  logic             PCSrcD,
    input  logic             RegWriteD,
    input  logic             MemtoRegD,
    input  logic             MemWriteD,
    input  logic             BranchD,
    input  logic             ALUSrcD,
    input  logic             MulD,
    input  logic [1:0]       FlagWriteD,
    input  logic [3:0]       ALUControlD,
    input  logic [3:0]       CondD,
    input  logic [AW-1:0]    WriteAddrD,
    input  logic [WIDTH-1:0] Rd1D,
    input  logic [WIDTH-1:0] Rd2D,
    input  logic [WIDTH-1:0] ExtD,
    input  logic [1:0]       ForwardAE,
    input  logic [1:0]       ForwardBE,
    input  logic [WIDTH-1:0] ResultW,
    output logic             PCSrcM,
    output logic             BranchM,
    output logic             RegWriteM,
    output logic             MemtoRegM,
    output logic             MemWriteM,
    output logic [WIDTH-1:0] ALUResultM,
    output logic [WIDTH-1:0] WriteDataM,
    output logic [AW-1:0]    WriteAddrM,
    output logic [3:0]       FlagsE,
    output logic             busyE
);

    typedef struct packed {
        logic             pc_src;
        logic             reg_write;
        logic             mem_to_reg;
        logic             mem_write;
        logic             branch;
        logic             alu_src;
`ifdef EXEC_MUL_EN
        logic             mul;
`endif
        logic [1:0]       flag_write;
        logic [3:0]       alu_ctrl;
        logic [3:0]       cond;
        logic [AW-1:0]    waddr;
        logic [WIDTH-1:0] rd1;
        logic [WIDTH-1:0] rd2;
        logic [WIDTH-1:0] ext;
    } de_t;

    typedef struct packed {
        logic             pc_src;
        logic             branch;
        logic             reg_write;
        logic             mem_to_reg;
        logic             mem_write;
        logic [AW-1:0]    waddr;
        logic [WIDTH-1:0] alu_result;
        logic [WIDTH-1:0] write_data;
    } em_t;

    de_t              de_q, de_d;
    em_t              em_q, em_d;
    logic [3:0]       flags_q, flags_d;
    logic             busy, mul_done, mul_abort, em_bubble;
    logic [WIDTH-1:0] src_a, fwd_b, src_b, alu_res, res_out, add_x, add_y;
    logic             add_cin, alu_c, alu_v, cond_ex;
    logic [WIDTH:0]   sum;
    logic             fn, fz, fc, fv;

    always_comb begin
        de_d = de_q;
        if (flushE) begin
            de_d = '0;
        end else if (!(stallE || busy)) begin
            de_d.pc_src     = PCSrcD;
            de_d.reg_write  = RegWriteD;
            de_d.mem_to_reg = MemtoRegD;
            de_d.mem_write  = MemWriteD;
            de_d.branch     = BranchD;
            de_d.alu_src    = ALUSrcD;
`ifdef EXEC_MUL_EN
            de_d.mul        = MulD;
`endif
            de_d.flag_write = FlagWriteD;
            de_d.alu_ctrl   = ALUControlD;
            de_d.cond       = CondD;
            de_d.waddr      = WriteAddrD;
            de_d.rd1        = Rd1D;
            de_d.rd2        = Rd2D;
            de_d.ext        = ExtD;
        end
    end

    always_comb begin
        case (ForwardAE)
            2'b01:   src_a = ResultW;
            2'b10:   src_a = em_q.alu_result;
            default: src_a = de_q.rd1;
        endcase
        case (ForwardBE)
            2'b01:   fwd_b = ResultW;
            2'b10:   fwd_b = em_q.alu_result;
            default: fwd_b = de_q.rd2;
        endcase
    end
    assign src_b = de_q.alu_src ? de_q.ext : fwd_b;

    // One adder serves ADD, SUB and RSB; subtraction adds the inverted operand plus one.
    always_comb begin
        add_x   = src_a;
        add_y   = src_b;
        add_cin = 1'b0;
        case (de_q.alu_ctrl)
            4'b0001: begin add_y = ~src_b; add_cin = 1'b1; end
            4'b0111: begin add_x = src_b; add_y = ~src_a; add_cin = 1'b1; end
            default: ;
        endcase
    end
    assign sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};

    always_comb begin
        alu_res = src_a;
        alu_c   = flags_q[1];
        alu_v   = flags_q[0];
        case (de_q.alu_ctrl)
            4'b0000, 4'b0001, 4'b0111: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (sum[WIDTH-1] != add_x[WIDTH-1]);
            end
            4'b0010: alu_res = src_a & src_b;
            4'b0011: alu_res = src_a | src_b;
            4'b0100: alu_res = src_a ^ src_b;
            4'b0101: alu_res = src_b;
            4'b0110: alu_res = ~src_b;
            default: alu_res = src_a;
        endcase
    end

    assign {fn, fz, fc, fv} = flags_q;
    always_comb begin
        case (de_q.cond)
            4'h0:    cond_ex = fz;
            4'h1:    cond_ex = !fz;
            4'h2:    cond_ex = fc;
            4'h3:    cond_ex = !fc;
            4'h4:    cond_ex = fn;
            4'h5:    cond_ex = !fn;
            4'h6:    cond_ex = fv;
            4'h7:    cond_ex = !fv;
            4'h8:    cond_ex = fc && !fz;
            4'h9:    cond_ex = !fc || fz;
            4'hA:    cond_ex = (fn == fv);
            4'hB:    cond_ex = (fn != fv);
            4'hC:    cond_ex = !fz && (fn == fv);
            4'hD:    cond_ex = fz || (fn != fv);
            4'hE:    cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

`ifdef EXEC_MUL_EN
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {MUL_IDLE, MUL_RUN, MUL_DONE} mul_state_t;

    mul_state_t       state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             mul_start;

    assign mul_start = (state_q == MUL_IDLE) && de_q.mul && cond_ex;
    assign busy      = mul_start || (state_q == MUL_RUN);
    assign mul_done  = (state_q == MUL_DONE);
    assign mul_abort = flushE && (state_q != MUL_IDLE);
    assign res_out   = mul_done ? acc_q : alu_res;

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        case (state_q)
            MUL_IDLE: if (mul_start) begin
                mcand_d  = src_a;
                mplier_d = src_b;
                acc_d    = '0;
                cnt_d    = CW'(WIDTH);
                state_d  = MUL_RUN;
            end
            MUL_RUN: begin
                acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) state_d = MUL_DONE;
            end
            default: state_d = MUL_IDLE;
        endcase
        if (flushE) state_d = MUL_IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= MUL_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end
`else
    logic mul_unused;
    assign mul_unused = MulD;
    assign busy       = 1'b0;
    assign mul_done   = 1'b0;
    assign mul_abort  = 1'b0;
    assign res_out    = alu_res;
`endif

    // A busy or aborted multiply sends a bubble to M and leaves the flags alone.
    assign em_bubble = busy || mul_abort;

    always_comb begin
        em_d.pc_src     = de_q.pc_src    && cond_ex && !em_bubble;
        em_d.branch     = de_q.branch    && cond_ex && !em_bubble;
        em_d.reg_write  = de_q.reg_write && cond_ex && !em_bubble;
        em_d.mem_write  = de_q.mem_write && cond_ex && !em_bubble;
        em_d.mem_to_reg = de_q.mem_to_reg && !em_bubble;
        em_d.waddr      = de_q.waddr;
        em_d.alu_result = res_out;
        em_d.write_data = fwd_b;
        flags_d = flags_q;
        if (!em_bubble && cond_ex) begin
            if (de_q.flag_write[1]) flags_d[3:2] = {res_out[WIDTH-1], res_out == '0};
            if (de_q.flag_write[0] && !mul_done) flags_d[1:0] = {alu_c, alu_v};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            de_q    <= '0;
            em_q    <= '0;
            flags_q <= '0;
        end else begin
            de_q    <= de_d;
            em_q    <= em_d;
            flags_q <= flags_d;
        end
    end

    assign PCSrcM     = em_q.pc_src;
    assign BranchM    = em_q.branch;
    assign RegWriteM  = em_q.reg_write;
    assign MemtoRegM  = em_q.mem_to_reg;
    assign MemWriteM  = em_q.mem_write;
    assign ALUResultM = em_q.alu_result;
    assign WriteDataM = em_q.write_data;
    assign WriteAddrM = em_q.waddr;
    assign FlagsE     = flags_q;
    assign busyE      = busy;

endmodule

// File: tb/tb_exec_stage_mc.sv
// Directed bench for exec_stage_mc (WIDTH=32); multiply checks run when EXEC_MUL_EN is defined.
module tb_exec_stage_mc;
    localparam int WIDTH = 32;
    localparam int AW    = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             stallE, flushE;
    logic             PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD, MulD;
    logic [1:0]       FlagWriteD;
    logic [3:0]       ALUControlD, CondD;
    logic [AW-1:0]    WriteAddrD;
    logic [WIDTH-1:0] Rd1D, Rd2D, ExtD;
    logic [1:0]       ForwardAE, ForwardBE;
    logic [WIDTH-1:0] ResultW;
    logic             PCSrcM, BranchM, RegWriteM, MemtoRegM, MemWriteM;
    logic [WIDTH-1:0] ALUResultM, WriteDataM;
    logic [AW-1:0]    WriteAddrM;
    logic [3:0]       FlagsE;
    logic             busyE;

    int n_tests = 0;
    int n_fail  = 0;
    int busy_cnt;

    exec_stage_mc #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .stallE(stallE), .flushE(flushE),
        .PCSrcD(PCSrcD), .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
        .BranchD(BranchD), .ALUSrcD(ALUSrcD), .MulD(MulD), .FlagWriteD(FlagWriteD),
        .ALUControlD(ALUControlD), .CondD(CondD), .WriteAddrD(WriteAddrD),
        .Rd1D(Rd1D), .Rd2D(Rd2D), .ExtD(ExtD), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ResultW(ResultW), .PCSrcM(PCSrcM), .BranchM(BranchM), .RegWriteM(RegWriteM),
        .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM), .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM), .WriteAddrM(WriteAddrM), .FlagsE(FlagsE), .busyE(busyE)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ext, input logic alusrc, input logic rw, input logic mw,
                         input logic [1:0] fw, input logic [3:0] cond, input logic [3:0] wa,
                         input logic mul);
        ALUControlD = ctrl; Rd1D = a; Rd2D = b; ExtD = ext; ALUSrcD = alusrc;
        RegWriteD = rw; MemWriteD = mw; FlagWriteD = fw; CondD = cond; WriteAddrD = wa;
        MulD = mul; PCSrcD = 1'b0; MemtoRegD = 1'b0; BranchD = 1'b0;
    endtask

    task automatic clr_d();
        set_d(4'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 4'h0, 4'h0, 1'b0);
    endtask

    // Issue one instruction, follow it with a bubble, and stop one tick after it reaches M.
    task automatic run_one();
        clk1();
        clr_d();
        clk1();
    endtask

    initial begin
        clr_d();
        stallE = 1'b0; flushE = 1'b0; ForwardAE = 2'b00; ForwardBE = 2'b00; ResultW = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_alu", ALUResultM, 32'h0);
        check("rst_flags", {28'h0, FlagsE}, 32'h0);
        check("rst_busy", {31'h0, busyE}, 32'h0);
        check("rst_rw", {31'h0, RegWriteM}, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        set_d(4'h0, 32'd5, 32'd7, 32'h0, 1'b0, 1'b1, 1'b0, 2'b11, 4'hE, 4'd3, 1'b0);
        run_one();
        check("add_res", ALUResultM, 32'd12);
        check("add_rw", {31'h0, RegWriteM}, 32'h1);
        check("add_wa", {28'h0, WriteAddrM}, 32'd3);
        check("add_flags", {28'h0, FlagsE}, 32'b0000);

        set_d(4'h1, 32'd3, 32'd3, 32'h0, 1'b0, 1'b1, 1'b0, 2'b11, 4'hE, 4'd4, 1'b0);
        run_one();
        check("sub_res", ALUResultM, 32'h0);
        check("sub_flags", {28'h0, FlagsE}, 32'b0110);

        set_d(4'h5, 32'h0, 32'h55, 32'h0, 1'b0, 1'b1, 1'b0, 2'b00, 4'h0, 4'd5, 1'b0);
        run_one();
        check("eq_rw", {31'h0, RegWriteM}, 32'h1);
        check("eq_res", ALUResultM, 32'h55);
        set_d(4'h5, 32'h0, 32'h66, 32'h0, 1'b0, 1'b1, 1'b0, 2'b00, 4'h1, 4'd6, 1'b0);
        run_one();
        check("ne_rw", {31'h0, RegWriteM}, 32'h0);

        set_d(4'h0, 32'h7FFFFFFF, 32'h1, 32'h0, 1'b0, 1'b1, 1'b0, 2'b11, 4'hE, 4'd1, 1'b0);
        run_one();
        check("ovf_res", ALUResultM, 32'h80000000);
        check("ovf_flags", {28'h0, FlagsE}, 32'b1001);
        set_d(4'h4, 32'h5, 32'h5, 32'h0, 1'b0, 1'b1, 1'b0, 2'b11, 4'hE, 4'd1, 1'b0);
        run_one();
        check("eor_flags", {28'h0, FlagsE}, 32'b0101);
        set_d(4'h7, 32'h5, 32'h3, 32'h0, 1'b0, 1'b1, 1'b0, 2'b11, 4'hE, 4'd1, 1'b0);
        run_one();
        check("rsb_res", ALUResultM, 32'hFFFFFFFE);
        check("rsb_flags", {28'h0, FlagsE}, 32'b1000);
        set_d(4'h0, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 1'b1, 1'b0, 2'b11, 4'hE, 4'd1, 1'b0);
        run_one();
        check("carry_res", ALUResultM, 32'h0);
        check("carry_flags", {28'h0, FlagsE}, 32'b0110);
        set_d(4'h6, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 2'b00, 4'hE, 4'd1, 1'b0);
        run_one();
        check("mvn_res", ALUResultM, 32'hFFFFFFFF);
        set_d(4'h9, 32'hABC, 32'h123, 32'h0, 1'b0, 1'b1, 1'b0, 2'b00, 4'hE, 4'd1, 1'b0);
        run_one();
        check("rsvd_res", ALUResultM, 32'hABC);

        set_d(4'h0, 32'd5, 32'd7, 32'h0, 1'b0, 1'b1, 1'b0, 2'b00, 4'hE, 4'd1, 1'b0);
        clk1();
        set_d(4'h0, 32'h999, 32'h0, 32'h1, 1'b1, 1'b1, 1'b0, 2'b00, 4'hE, 4'd2, 1'b0);
        clk1();
        check("fwd_first", ALUResultM, 32'd12);
        ForwardAE = 2'b10;
        clr_d();
        clk1();
        check("fwd_a_res", ALUResultM, 32'd13);
        ForwardAE = 2'b00;

        set_d(4'h0, 32'h10, 32'h20, 32'h4, 1'b1, 1'b0, 1'b1, 2'b00, 4'hE, 4'd0, 1'b0);
        clk1();
        ForwardBE = 2'b01;
        ResultW = 32'h100;
        clr_d();
        clk1();
        check("fwd_b_data", WriteDataM, 32'h100);
        check("fwd_b_mw", {31'h0, MemWriteM}, 32'h1);
        check("fwd_b_res", ALUResultM, 32'h14);
        ForwardBE = 2'b11;
        set_d(4'h0, 32'h0, 32'h77, 32'h0, 1'b1, 1'b0, 1'b1, 2'b00, 4'hE, 4'd0, 1'b0);
        run_one();
        check("fwd_b_rsvd", WriteDataM, 32'h77);
        ForwardBE = 2'b00;

        set_d(4'h5, 32'h0, 32'h42, 32'h0, 1'b0, 1'b1, 1'b0, 2'b00, 4'hE, 4'd8, 1'b0);
        clk1();
        stallE = 1'b1;
        set_d(4'h5, 32'h0, 32'h99, 32'h0, 1'b0, 1'b1, 1'b0, 2'b00, 4'hE, 4'd9, 1'b0);
        clk1();
        stallE = 1'b0;
        clr_d();
        clk1();
        check("stall_res", ALUResultM, 32'h42);
        check("stall_wa", {28'h0, WriteAddrM}, 32'd8);

        set_d(4'h5, 32'h0, 32'h33, 32'h0, 1'b0, 1'b1, 1'b0, 2'b00, 4'hE, 4'd9, 1'b0);
        flushE = 1'b1;
        clk1();
        flushE = 1'b0;
        clr_d();
        clk1();
        check("flush_rw", {31'h0, RegWriteM}, 32'h0);
        check("flush_res", ALUResultM, 32'h0);

`ifdef EXEC_MUL_EN
        set_d(4'h0, 32'hFFFFFFFF, 32'h3, 32'h0, 1'b0, 1'b1, 1'b0, 2'b10, 4'hE, 4'd7, 1'b1);
        clk1();
        clr_d();
        busy_cnt = 0;
        for (int i = 0; i < 100 && busyE; i++) begin
            busy_cnt++;
            clk1();
        end
        check("mul_busy_cycles", busy_cnt, 32'd33);
        check("mul_bubble_rw", {31'h0, RegWriteM}, 32'h0);
        clk1();
        check("mul_res", ALUResultM, 32'hFFFFFFFD);
        check("mul_rw", {31'h0, RegWriteM}, 32'h1);
        check("mul_wa", {28'h0, WriteAddrM}, 32'd7);
        check("mul_flags", {28'h0, FlagsE}, 32'b1010);

        set_d(4'h0, 32'h2, 32'h3, 32'h0, 1'b0, 1'b1, 1'b0, 2'b11, 4'h0, 4'd7, 1'b1);
        clk1();
        check("mul_nc_busy", {31'h0, busyE}, 32'h0);
        clr_d();
        clk1();
        check("mul_nc_rw", {31'h0, RegWriteM}, 32'h0);
        check("mul_nc_flags", {28'h0, FlagsE}, 32'b1010);

        set_d(4'h0, 32'h2, 32'h3, 32'h0, 1'b0, 1'b1, 1'b0, 2'b11, 4'hE, 4'd7, 1'b1);
        clk1();
        clr_d();
        repeat (10) clk1();
        check("mf_busy_pre", {31'h0, busyE}, 32'h1);
        flushE = 1'b1;
        clk1();
        flushE = 1'b0;
        check("mf_busy", {31'h0, busyE}, 32'h0);
        check("mf_rw", {31'h0, RegWriteM}, 32'h0);
        check("mf_flags", {28'h0, FlagsE}, 32'b1010);
        clk1();
        check("mf_rw2", {31'h0, RegWriteM}, 32'h0);
        check("mf_flags2", {28'h0, FlagsE}, 32'b1010);

        set_d(4'h0, 32'h2, 32'h3, 32'h0, 1'b0, 1'b1, 1'b0, 2'b11, 4'hE, 4'd7, 1'b1);
        clk1();
        clr_d();
        repeat (5) clk1();
        check("ar_busy_pre", {31'h0, busyE}, 32'h1);
`else
        set_d(4'h0, 32'hFFFFFFFF, 32'h3, 32'h0, 1'b0, 1'b1, 1'b0, 2'b10, 4'hE, 4'd7, 1'b1);
        clk1();
        check("nomul_busy", {31'h0, busyE}, 32'h0);
        clr_d();
        clk1();
        check("nomul_res", ALUResultM, 32'h2);
        check("nomul_flags", {28'h0, FlagsE}, 32'b0010);
        set_d(4'h5, 32'h0, 32'h1234, 32'h0, 1'b0, 1'b1, 1'b0, 2'b00, 4'hE, 4'd5, 1'b0);
        run_one();
`endif
        #2;
        reset = 1'b0;
        #1;
        check("ar_alu", ALUResultM, 32'h0);
        check("ar_wa", {28'h0, WriteAddrM}, 32'h0);
        check("ar_flags", {28'h0, FlagsE}, 32'h0);
        check("ar_busy", {31'h0, busyE}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        set_d(4'h0, 32'd5, 32'd7, 32'h0, 1'b0, 1'b1, 1'b0, 2'b11, 4'hE, 4'd3, 1'b0);
        run_one();
        check("post_rst_res", ALUResultM, 32'd12);
        check("post_rst_rw", {31'h0, RegWriteM}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
